// File: rtl/button_gesture_pkg.sv
// Shared types and elaboration helpers for the button gesture decoder.
// Optional hold auto-repeat is enabled by defining GESTURE_REPEAT_EN.
package button_gesture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HELD
    } state_t;

    // Counter must be able to hold the largest terminal count.
    function automatic int cnt_width(input int long_t, input int dbl_t, input int rpt_t);
        int m;
        m = long_t;
        if (dbl_t > m) m = dbl_t;
        if (rpt_t > m) m = rpt_t;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_legal(input int long_t, input int dbl_t, input int rpt_t);
        return (long_t >= 2) && (dbl_t >= 2) && (rpt_t >= 1);
    endfunction

endpackage

// File: rtl/button_gesture_decoder_timer.sv
// Saturating tick counter; clear has priority and counts only on clock_enable.
module gesture_tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         clock_enable,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (clock_enable && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button activity into single click, double click and long press.
// Define GESTURE_REPEAT_EN to emit hold_repeat pulses while a long press is held.
module button_gesture_decoder
    import button_gesture_pkg::*;
#(
    parameter int LONG_TICKS   = 1000,
    parameter int DOUBLE_TICKS = 250,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clock_enable,
    input  logic btn_level,
    input  logic btn_press,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic hold_repeat,
    output logic busy
);

    localparam int W = cnt_width(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS);

    if (!params_legal(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS)) begin : g_bad_params
        $error("button_gesture_decoder: illegal tick parameters");
    end

    state_t         state;
    logic [W-1:0]   cnt;
    logic           clear;
    logic           rel;
    logic           long_hit;
    logic           dbl_to;
    logic           rpt_hit;

    always_comb begin
        rel      = !btn_level;
        long_hit = clock_enable && (cnt == W'(LONG_TICKS - 1));
        dbl_to   = clock_enable && (cnt == W'(DOUBLE_TICKS - 1));
`ifdef GESTURE_REPEAT_EN
        rpt_hit  = clock_enable && (cnt == W'(REPEAT_TICKS - 1));
`else
        rpt_hit  = 1'b0;
`endif
        // Clear exactly on the edges where the FSM leaves its state (or re-arms a repeat).
        clear = 1'b0;
        case (state)
            IDLE:      clear = btn_press;
            PRESS1:    clear = long_hit || rel;
            WAIT2:     clear = btn_press || dbl_to;
            PRESS2:    clear = rel;
            LONG_HELD: clear = rel || rpt_hit;
            default:   clear = 1'b1;
        endcase
    end

    gesture_tick_timer #(.W(W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .clock_enable (clock_enable),
        .cnt          (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            hold_repeat  <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            hold_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_press) state <= PRESS1;
                end
                PRESS1: begin
                    if (long_hit) begin
                        long_press <= 1'b1;
                        state      <= LONG_HELD;
                    end else if (rel) begin
                        state <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (btn_press) begin
                        state <= PRESS2;
                    end else if (dbl_to) begin
                        single_click <= 1'b1;
                        state        <= IDLE;
                    end
                end
                PRESS2: begin
                    if (rel) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end
                end
                LONG_HELD: begin
                    if (rel)
                        state <= IDLE;
                    else if (rpt_hit)
                        hold_repeat <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench: stimulus pushes expected pulses (kind, cycle), a negedge monitor pops and compares.
module tb_button_gesture_decoder;

    localparam int L = 8;
    localparam int D = 4;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clock_enable = 1'b0;
    logic btn_level = 1'b0;
    logic btn_press = 1'b0;
    logic single_click, double_click, long_press, hold_repeat, busy;

    button_gesture_decoder #(
        .LONG_TICKS   (L),
        .DOUBLE_TICKS (D),
        .REPEAT_TICKS (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clock_enable (clock_enable),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .hold_repeat  (hold_repeat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_SINGLE, EV_DOUBLE, EV_LONG, EV_REPEAT} ev_t;
    typedef struct {
        ev_t kind;
        int  at;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   slow_ce = 1'b0;
    bit   mon_en = 1'b0;

    // Each call advances n clock edges; in slow mode only edges divisible by 4 carry a tick.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            clock_enable = slow_ce ? (((cyc + 1) % 4) == 0) : 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press();
        btn_level = 1'b1;
        btn_press = 1'b1;
        step(1);
        btn_press = 1'b0;
    endtask

    task automatic release_btn();
        btn_level = 1'b0;
        step(1);
    endtask

    task automatic expect_ev(input ev_t k, input int at);
        exp_t e;
        e.kind = k;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int nth_tick(input int from, input int n);
        return from + (4 - (from % 4)) + 4 * (n - 1);
    endfunction

    always @(negedge clk) begin : monitor
        int   n;
        ev_t  k;
        exp_t e;
        if (mon_en) begin
            n = $countones({single_click, double_click, long_press, hold_repeat});
            if (n > 1) begin
                vectors++;
                miscompares++;
                $display("FAIL multi_pulse: %0d pulses high, want at most 1 (cycle %0d)", n, cyc);
            end
            if (n != 0) begin
                k = single_click ? EV_SINGLE : double_click ? EV_DOUBLE :
                    long_press ? EV_LONG : EV_REPEAT;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: got %s at cycle %0d, want none", k.name(), cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || e.at != cyc) begin
                        miscompares++;
                        $display("FAIL pulse: got %s at cycle %0d, want %s at cycle %0d",
                                 k.name(), cyc, e.kind.name(), e.at);
                    end
                end
            end
        end
    end

    initial begin
        int   p, r;
        exp_t e;

        rst_n = 1'b0;
        step(3);
        check("rst_single", single_click, 1'b0);
        check("rst_double", double_click, 1'b0);
        check("rst_long",   long_press,   1'b0);
        check("rst_repeat", hold_repeat,  1'b0);
        check("rst_busy",   busy,         1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        step(2);

        // 1: single click
        press();
        check("t1_busy_pressed", busy, 1'b1);
        step(2);
        release_btn();
        r = cyc;
        expect_ev(EV_SINGLE, r + 4);
        step(10);
        check("t1_busy_idle", busy, 1'b0);

        // 2: double click
        press();
        step(1);
        release_btn();
        step(1);
        press();
        step(1);
        release_btn();
        expect_ev(EV_DOUBLE, cyc);
        step(8);
        check("t2_busy_idle", busy, 1'b0);

        // 3: long press with optional auto-repeat
        press();
        p = cyc;
        expect_ev(EV_LONG, p + 8);
`ifdef GESTURE_REPEAT_EN
        for (int k = 11; k <= 20; k += 3) expect_ev(EV_REPEAT, p + k);
`endif
        step(20);
        release_btn();
        step(5);
        check("t3_busy_idle", busy, 1'b0);

        // 4a: release collides with long timeout
        press();
        p = cyc;
        step(7);
        expect_ev(EV_LONG, p + 8);
        release_btn();
        step(6);
        check("t4a_busy_idle", busy, 1'b0);

        // 4b: second press collides with double-click timeout
        press();
        step(1);
        release_btn();
        r = cyc;
        step(3);
        press();
        check("t4b_in_press2", busy, 1'b1);
        step(1);
        release_btn();
        expect_ev(EV_DOUBLE, cyc);
        step(8);

        // 5: slow ticks
        slow_ce = 1'b1;
        press();
        step(19);
        release_btn();
        r = cyc;
        expect_ev(EV_SINGLE, nth_tick(r, 4));
        step(20);
        check("t5_busy_after_single", busy, 1'b0);
        press();
        p = cyc;
        expect_ev(EV_LONG, nth_tick(p, 8));
        step(32);
        release_btn();
        step(4);
        slow_ce = 1'b0;
        step(2);
        check("t5_busy_idle", busy, 1'b0);

        // 6: reset mid-gesture in each busy state
        press();
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t6_rst_press1", busy, 1'b0);
        release_btn();
        step(3);

        press();
        step(1);
        release_btn();
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t6_rst_wait2", busy, 1'b0);
        step(8);

        press();
        p = cyc;
        expect_ev(EV_LONG, p + 8);
        step(10);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t6_rst_long", busy, 1'b0);
        release_btn();
        step(3);

        press();
        step(2);
        release_btn();
        r = cyc;
        expect_ev(EV_SINGLE, r + 4);
        step(10);
        check("t6_recover_idle", busy, 1'b0);

        step(2);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: got none, want %s at cycle %0d", e.kind.name(), e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
